tpu_unit: RTL and testbench

// Timer/slot unit behind an 8-bit register bus: register file, 16-bit interval timer, TX/RX slot pulse generator.

---
 rtl/tpu_unit_if.sv | 9 +
 rtl/tpu_unit.sv | 64 ++++++
 tb/tb_tpu_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tpu_unit_if.sv
// tpu_unit_if: 8-bit register bus between a host and the timer/slot unit
interface tpu_unit_if;
  logic       valid;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  modport master (output valid, addr, data_in, input data_out);
  modport slave (input valid, addr, data_in, output data_out);
endinterface

// File: rtl/tpu_unit.sv
// tpu_unit: register-bus interval timer with wrap interrupt and TX/RX slot strobes
module tpu_unit #(
  parameter logic [7:0] BASE_ADDR = 8'h20
) (
  input  logic        sys_clock,
  input  logic        reset,
  tpu_unit_if.slave   bus,
  output logic        g_clk_tx,
  output logic        g_clk_rx,
  output logic        tpu_int,
  output logic [15:0] counter
);
  logic [4:0] ctrl_q, ctrl_d;
  logic [7:0] top0_q, top0_d, top1_q, top1_d, tx_q, tx_d, rx_q, rx_d, off;
  logic [15:0] cnt_q, cnt_d, top;
  logic gtx_q, gtx_d, grx_q, grx_d, hold, wrap, wr_ctrl;
  always_comb begin
    off = bus.addr - BASE_ADDR;
    top = {top1_q, top0_q};
    hold = ctrl_q[0];
    wrap = ~hold & (cnt_q >= top);
    wr_ctrl = bus.valid & (off == 8'd0);
    cnt_d = (hold | wrap) ? 16'h0000 : cnt_q + 16'h0001;
    gtx_d = ctrl_q[1] & ~hold & (cnt_q == {8'h00, tx_q});
    grx_d = ctrl_q[2] & ~hold & (cnt_q == {8'h00, rx_q});
    ctrl_d[3:0] = wr_ctrl ? bus.data_in[3:0] : ctrl_q[3:0];
    // a wrap on the same edge as a write-1-to-clear keeps the flag set
    ctrl_d[4] = wrap | (ctrl_q[4] & ~(wr_ctrl & bus.data_in[4]));
    top0_d = (bus.valid && off == 8'd1) ? bus.data_in : top0_q;
    top1_d = (bus.valid && off == 8'd2) ? bus.data_in : top1_q;
    tx_d = (bus.valid && off == 8'd3) ? bus.data_in : tx_q;
    rx_d = (bus.valid && off == 8'd4) ? bus.data_in : rx_q;
  end
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      ctrl_q <= '0;
      top0_q <= '0;
      top1_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      gtx_q <= 1'b0;
      grx_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      top0_q <= top0_d;
      top1_q <= top1_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      gtx_q <= gtx_d;
      grx_q <= grx_d;
    end
  end
  assign bus.data_out = (off == 8'd0) ? {3'b000, ctrl_q} :
                        (off == 8'd1) ? top0_q :
                        (off == 8'd2) ? top1_q :
                        (off == 8'd3) ? tx_q :
                        (off == 8'd4) ? rx_q : 8'h00;
  assign g_clk_tx = gtx_q;
  assign g_clk_rx = grx_q;
  assign tpu_int = ctrl_q[4] & ctrl_q[3];
  assign counter = cnt_q;
endmodule

// File: tb/tb_tpu_unit.sv
// tb_tpu_unit: directed and randomized checks of tpu_unit against a cycle-level behavioural model
module tb_tpu_unit;
  logic clk = 1'b0;
  logic rst;
  logic gtx, grx, tint;
  logic [15:0] cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tpu_unit_if bus ();
  tpu_unit #(.BASE_ADDR(8'h20)) dut (
    .sys_clock(clk), .reset(rst), .bus(bus),
    .g_clk_tx(gtx), .g_clk_rx(grx), .tpu_int(tint), .counter(cnt)
  );
  // model: five byte registers (flag kept separately), count and strobes
  logic [7:0] m_reg [5];
  bit m_flag, m_gtx, m_grx;
  int m_cnt;
  function automatic logic [7:0] m_rd(input logic [7:0] a);
    if (a == 8'h20) return {3'b000, m_flag, m_reg[0][3:0]};
    if (a > 8'h20 && a <= 8'h24) return m_reg[a - 8'h20];
    return 8'h00;
  endfunction
  task automatic step();
    int top = int'({m_reg[2], m_reg[1]});
    bit hold = m_reg[0][0];
    bit wrap = !hold && (m_cnt >= top);
    int nc = (hold || wrap) ? 0 : m_cnt + 1;
    bit ntx = m_reg[0][1] && !hold && (m_cnt == int'(m_reg[3]));
    bit nrx = m_reg[0][2] && !hold && (m_cnt == int'(m_reg[4]));
    bit v = bus.valid;
    bit r = rst;
    bit clr = 0;
    logic [7:0] a = bus.addr;
    logic [7:0] d = bus.data_in;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_flag = 0; m_cnt = 0; m_gtx = 0; m_grx = 0;
    end else begin
      if (v && a == 8'h20) begin
        m_reg[0] = d & 8'h0F;
        clr = d[4];
      end else if (v && a > 8'h20 && a <= 8'h24) m_reg[a - 8'h20] = d;
      m_flag = wrap ? 1'b1 : (m_flag && !clr);
      m_cnt = nc; m_gtx = ntx; m_grx = nrx;
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.valid = 1'b1; bus.addr = a; bus.data_in = d;
    step();
    bus.valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.valid = 1'b0; bus.addr = 8'h20; bus.data_in = 8'h00;
    step(); step();
    rst = 1'b0;
    for (int a = 8'h20; a <= 8'h24; a++) begin
      bus.addr = 8'(a); #1;
      checks++;
      if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_reg %h got %h want 00", a, bus.data_out); end
    end
    checks++;
    if ({cnt, gtx, grx, tint} !== 19'h0) begin errors++; $display("FAIL reset_out got cnt=%h tx=%b rx=%b int=%b want 0", cnt, gtx, grx, tint); end
    wr(8'h25, 8'hAA);
    bus.addr = 8'h25; #1;
    checks++;
    if (bus.data_out !== 8'h00) begin errors++; $display("FAIL unmapped got %h want 00", bus.data_out); end
  endtask
  task automatic test_hold();
    wr(8'h21, 8'h05); wr(8'h22, 8'h06); wr(8'h23, 8'h00); wr(8'h24, 8'h04);
    wr(8'h20, 8'h1F);
    repeat (5) begin
      step();
      checks++;
      if (cnt !== 16'h0 || gtx !== 1'b0 || grx !== 1'b0) begin errors++; $display("FAIL hold got cnt=%h tx=%b rx=%b want 0", cnt, gtx, grx); end
    end
    bus.addr = 8'h20; #1;
    checks++;
    if (bus.data_out !== 8'h0F || m_rd(8'h20) !== 8'h0F) begin errors++; $display("FAIL hold_ctrl got %h want 0f", bus.data_out); end
  endtask
  task automatic test_count();
    int ntx = 0, nrx = 0, mx = 0;
    bit ptx = 0, prx = 0;
    wr(8'h24, 8'h08);
    wr(8'h20, 8'h0E);
    for (int k = 1; k <= 1542; k++) begin
      step();
      if (k == 1541) begin
        checks++;
        if (tint !== 1'b0) begin errors++; $display("FAIL early_int got %b want 0", tint); end
      end
      if (cnt !== 16'(m_cnt) || gtx !== m_gtx || grx !== m_grx) begin
        errors++; $display("FAIL count_cyc k=%0d got cnt=%h tx=%b rx=%b want cnt=%h tx=%b rx=%b", k, cnt, gtx, grx, m_cnt, m_gtx, m_grx);
      end
      if ((gtx && ptx) || (grx && prx)) begin errors++; $display("FAIL pulse_width k=%0d tx=%b rx=%b want single cycle", k, gtx, grx); end
      ntx += int'(gtx); nrx += int'(grx); ptx = gtx; prx = grx;
      if (int'(cnt) > mx) mx = int'(cnt);
    end
    checks += 3;
    if (ntx != 1 || nrx != 1) begin errors++; $display("FAIL pulses got tx=%0d rx=%0d want 1 1", ntx, nrx); end
    if (mx != 16'h0605 || cnt !== 16'h0) begin errors++; $display("FAIL wrap got max=%h cnt=%h want 0605 0000", mx, cnt); end
    bus.addr = 8'h20; #1;
    if (bus.data_out !== 8'h1E || tint !== 1'b1) begin errors++; $display("FAIL int_set got %h int=%b want 1e 1", bus.data_out, tint); end
    wr(8'h20, 8'h1E);
    checks++;
    if (bus.data_out !== 8'h0E || tint !== 1'b0) begin errors++; $display("FAIL w1c got %h int=%b want 0e 0", bus.data_out, tint); end
  endtask
  task automatic test_mask();
    int n = 0;
    wr(8'h20, 8'h06);
    while (!m_flag && n < 2000) begin step(); n++; end
    bus.addr = 8'h20; #1;
    checks++;
    if (n >= 2000 || bus.data_out !== 8'h16 || tint !== 1'b0) begin errors++; $display("FAIL masked got %h int=%b want 16 0", bus.data_out, tint); end
    wr(8'h20, 8'h16);
    checks++;
    if (bus.data_out !== 8'h06) begin errors++; $display("FAIL mask_clr got %h want 06", bus.data_out); end
    n = 0;
    while (cnt !== 16'h0605 && n < 2000) begin step(); n++; end
    wr(8'h20, 8'h16);
    checks++;
    if (n >= 2000 || bus.data_out !== 8'h16 || cnt !== 16'h0) begin errors++; $display("FAIL same_edge got %h cnt=%h want 16 0000", bus.data_out, cnt); end
  endtask
  task automatic test_top();
    int n = 0;
    while (cnt !== 16'd100 && n < 2000) begin step(); n++; end
    wr(8'h21, 8'h03);
    wr(8'h22, 8'h00);
    step();
    checks++;
    if (n >= 2000 || cnt !== 16'h0) begin errors++; $display("FAIL top_lower got %h want 0000", cnt); end
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (cnt !== 16'(i % 4) || grx !== 1'b0 || gtx !== m_gtx) begin
        errors++; $display("FAIL period4 i=%0d got cnt=%h rx=%b tx=%b want %h 0 %b", i, cnt, grx, gtx, i % 4, m_gtx);
      end
    end
  endtask
  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({cnt, gtx, grx, tint} !== 19'h0) begin errors++; $display("FAIL mid_reset got cnt=%h tx=%b rx=%b int=%b want 0", cnt, gtx, grx, tint); end
    for (int a = 8'h20; a <= 8'h24; a++) begin
      bus.addr = 8'(a); #1;
      checks++;
      if (bus.data_out !== 8'h00) begin errors++; $display("FAIL mid_reset_reg %h got %h want 00", a, bus.data_out); end
    end
  endtask
  task automatic test_random();
    logic [7:0] a, d;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      a = 8'($urandom_range(8'h1E, 8'h26));
      d = 8'($urandom);
      if (a == 8'h21) d = 8'($urandom_range(0, 23));
      if (a == 8'h22) d = 8'h00;
      if (a == 8'h23 || a == 8'h24) d = 8'($urandom_range(0, 24));
      bus.valid = ($urandom_range(0, 3) == 0); bus.addr = a; bus.data_in = d;
      step();
      bus.valid = 1'b0;
      bus.addr = 8'($urandom_range(8'h1E, 8'h26)); #1;
      checks++;
      if (cnt !== 16'(m_cnt) || gtx !== m_gtx || grx !== m_grx || tint !== (m_flag && m_reg[0][3]) || bus.data_out !== m_rd(bus.addr)) begin
        errors++;
        $display("FAIL random k=%0d got cnt=%h tx=%b rx=%b int=%b rd[%h]=%h want cnt=%h tx=%b rx=%b int=%b rd=%h",
                 k, cnt, gtx, grx, tint, bus.addr, bus.data_out, m_cnt, m_gtx, m_grx, m_flag && m_reg[0][3], m_rd(bus.addr));
      end
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_hold();
    test_count();
    test_mask();
    test_top();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
